sha_ctrl: RTL

- Control FSM for the SHA-256 compression datapath. It sequences one 512-bit block at a time:
  - loads 16 message words over a valid/ready handshake;
  - drives 64 round-enable cycles, with the round index used as the K-ROM / W-schedule address;
  - issues the final hash-update strobe.
- Sits between the message-input interface and the round datapath. It replaces ad-hoc enable/flag sequencing with a single owner of all datapath strobes.

---
 rtl/sha_pkg.sv | 22 ++
 rtl/sha_step_cnt.sv | 46 ++++
 rtl/sha_ctrl.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/sha_pkg.sv
// Shared constants and state encoding for the SHA-256 block controller.
package sha_pkg;

    // Default geometry of one SHA-256 compression block.
    localparam int ROUNDS_DEF     = 64;
    localparam int CNT_SIZE_DEF   = 6;
    localparam int WORDS_DEF      = 16;
    localparam int WADDR_SIZE_DEF = 4;

    // The K-ROM holds one constant per round.
    localparam int K_ROM_DEPTH    = ROUNDS_DEF;

    // One-hot controller states.
    typedef enum logic [4:0] {
        S_IDLE   = 5'b00001,
        S_LOAD   = 5'b00010,
        S_ROUND  = 5'b00100,
        S_UPDATE = 5'b01000,
        S_DONE   = 5'b10000
    } state_t;

endpackage

// File: rtl/sha_step_cnt.sv
// Enable/clear step counter that wraps to zero after its terminal value.
// Clear has priority over enable. The terminal flag is decoded from the
// registered count.
module sha_step_cnt
    import sha_pkg::*;
#(
    parameter int MAX   = WORDS_DEF - 1,
    parameter int WIDTH = WADDR_SIZE_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] cnt_o,
    output logic             tc_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic             tc;

    assign tc = (cnt_q == WIDTH'(MAX));

    // Next count: clear wins, otherwise step and wrap at the terminal value.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = tc ? '0 : cnt_q + WIDTH'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign tc_o  = tc;

endmodule

// File: rtl/sha_ctrl.sv
// SHA-256 compression controller: loads one 512-bit block word by word,
// runs the round sequence and issues the hash-update / completion strobes.
// It is the single owner of every datapath strobe.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   S_IDLE   | waiting for start; no strobes active
//   S_LOAD   | accepting message words on the valid/ready handshake
//   S_ROUND  | one compression round per cycle, index = K-ROM/W address
//   S_UPDATE | single cycle: H += working variables
//   S_DONE   | final digest valid, held until the consumer accepts it
//
// All outputs come straight from flops. The start-cycle value of i_first
// is captured directly into the init-hash pulse flop, which is the only
// place the first-of-message flag is ever consumed.
module sha_ctrl
    import sha_pkg::*;
#(
    parameter int ROUNDS     = ROUNDS_DEF,
    parameter int CNT_SIZE   = CNT_SIZE_DEF,
    parameter int WORDS      = WORDS_DEF,
    parameter int WADDR_SIZE = WADDR_SIZE_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_start,
    input  logic                  i_first,
    input  logic                  i_last,
    input  logic                  i_abort,
    input  logic                  i_msg_valid,
    output logic                  o_msg_ready,
    output logic [WADDR_SIZE-1:0] o_word_addr,
    output logic                  o_init_hash,
    output logic                  o_round_en,
    output logic [CNT_SIZE-1:0]   o_round_idx,
    output logic                  o_hash_upd,
    output logic                  o_block_done,
    output logic                  o_digest_valid,
    input  logic                  i_digest_ready,
    output logic                  o_busy
);

    state_t state_q;
    logic   last_q;
    logic   msg_ready_q;
    logic   init_hash_q;
    logic   round_en_q;
    logic   hash_upd_q;
    logic   block_done_q;
    logic   digest_valid_q;
    logic   busy_q;

    logic   word_accept;
    logic   word_tc;
    logic   round_tc;

    logic [WADDR_SIZE-1:0] word_addr;
    logic [CNT_SIZE-1:0]   round_idx;

    assign word_accept = msg_ready_q & i_msg_valid;

    sha_step_cnt #(
        .MAX   (WORDS - 1),
        .WIDTH (WADDR_SIZE)
    ) u_word_cnt (
        .clk   (clk),
        .reset (reset),
        .clr_i (i_abort),
        .en_i  (word_accept),
        .cnt_o (word_addr),
        .tc_o  (word_tc)
    );

    sha_step_cnt #(
        .MAX   (ROUNDS - 1),
        .WIDTH (CNT_SIZE)
    ) u_round_cnt (
        .clk   (clk),
        .reset (reset),
        .clr_i (i_abort),
        .en_i  (round_en_q),
        .cnt_o (round_idx),
        .tc_o  (round_tc)
    );

    // Block sequencer with registered strobes; abort overrides every state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            last_q         <= 1'b0;
            msg_ready_q    <= 1'b0;
            init_hash_q    <= 1'b0;
            round_en_q     <= 1'b0;
            hash_upd_q     <= 1'b0;
            block_done_q   <= 1'b0;
            digest_valid_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            init_hash_q  <= 1'b0;
            hash_upd_q   <= 1'b0;
            block_done_q <= 1'b0;
            if (i_abort) begin
                state_q        <= S_IDLE;
                last_q         <= 1'b0;
                msg_ready_q    <= 1'b0;
                round_en_q     <= 1'b0;
                digest_valid_q <= 1'b0;
                busy_q         <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (i_start) begin
                            state_q     <= S_LOAD;
                            last_q      <= i_last;
                            init_hash_q <= i_first;
                            msg_ready_q <= 1'b1;
                            busy_q      <= 1'b1;
                        end
                    end
                    S_LOAD: begin
                        if (word_accept && word_tc) begin
                            state_q     <= S_ROUND;
                            msg_ready_q <= 1'b0;
                            round_en_q  <= 1'b1;
                        end
                    end
                    S_ROUND: begin
                        if (round_tc) begin
                            state_q      <= S_UPDATE;
                            round_en_q   <= 1'b0;
                            hash_upd_q   <= 1'b1;
                            block_done_q <= ~last_q;
                        end
                    end
                    S_UPDATE: begin
                        if (last_q) begin
                            state_q        <= S_DONE;
                            digest_valid_q <= 1'b1;
                        end else begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                    S_DONE: begin
                        if (i_digest_ready) begin
                            state_q        <= S_IDLE;
                            last_q         <= 1'b0;
                            digest_valid_q <= 1'b0;
                            busy_q         <= 1'b0;
                        end
                    end
                    default: begin
                        state_q        <= S_IDLE;
                        last_q         <= 1'b0;
                        msg_ready_q    <= 1'b0;
                        round_en_q     <= 1'b0;
                        digest_valid_q <= 1'b0;
                        busy_q         <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_msg_ready    = msg_ready_q;
    assign o_word_addr    = word_addr;
    assign o_init_hash    = init_hash_q;
    assign o_round_en     = round_en_q;
    assign o_round_idx    = round_idx;
    assign o_hash_upd     = hash_upd_q;
    assign o_block_done   = block_done_q;
    assign o_digest_valid = digest_valid_q;
    assign o_busy         = busy_q;

endmodule
